// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_st_t;

  // Index width for n entries; a single-entry index still needs one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req at or after base, wrapping.
// Zero latency; no state, no backpressure.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      int c;
      c = int'(base) + i;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = W'(c);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with burst lock in front of the fifo_sync write port.
// Zero-latency grant path; fifo_full stalls the grantee without losing or re-arbitrating the lock.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int REQ_W      = idx_width(NUM_REQ),
  localparam int BURST_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_valid,
  output logic [REQ_W-1:0]              grant_id
);

  arb_st_t            st;
  logic [REQ_W-1:0]   rr_ptr;
  logic [REQ_W-1:0]   owner;
  logic [BURST_W-1:0] beat_cnt;
  logic [BURST_W-1:0] beat_nxt;
  logic               pick_found;
  logic [REQ_W-1:0]   pick_idx;
  logic [REQ_W-1:0]   cand_id;

  function automatic logic [REQ_W-1:0] wrap_inc(input logic [REQ_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ), .W(REQ_W)) u_pick (
    .req   (req_valid),
    .base  (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign beat_nxt = beat_cnt + BURST_W'(1);

  always_comb begin
    cand_id      = (st == ARB_LOCKED) ? owner : pick_idx;
    grant_valid  = !rst && ((st == ARB_LOCKED) ? req_valid[owner] : pick_found);
    grant_id     = grant_valid ? cand_id : '0;
    req_ready    = '0;
    if (grant_valid && !fifo_full) req_ready[grant_id] = 1'b1;
    fifo_wr_en   = |req_ready;
    fifo_wr_data = grant_valid ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ARB_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      case (st)
        ARB_IDLE: begin
          if (fifo_wr_en) begin
            if (MAX_BURST == 1) begin
              rr_ptr <= wrap_inc(pick_idx);
            end else begin
              st       <= ARB_LOCKED;
              owner    <= pick_idx;
              beat_cnt <= BURST_W'(1);
            end
          end
        end
        ARB_LOCKED: begin
          // Owner going idle ends the burst; that cycle carries no grant.
          if (!req_valid[owner]) begin
            st       <= ARB_IDLE;
            rr_ptr   <= wrap_inc(owner);
            beat_cnt <= '0;
          end else if (fifo_wr_en) begin
            if (beat_nxt == BURST_W'(MAX_BURST)) begin
              st       <= ARB_IDLE;
              rr_ptr   <= wrap_inc(owner);
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_nxt;
            end
          end
        end
        default: st <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: MAX_BURST=1 and MAX_BURST=4 instances share stimulus, one observed at a time.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  vld = '0;
  logic [31:0] dat = 32'h3020_1000;
  logic        full = 1'b0;
  logic        use1 = 1'b1;

  logic [3:0] rr1, rr4, rr_o;
  logic       we1, we4, we_o, gv1, gv4, gv_o;
  logic [7:0] wd1, wd4, wd_o;
  logic [1:0] gid1, gid4, gid_o;

  int checks = 0;
  int failures = 0;
  int writes = 0;
  int accepted = 0;
  logic [9:0] exp_q[$];
  logic [7:0] sink_q[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(vld), .req_data(dat), .req_ready(rr1),
    .fifo_full(full), .fifo_wr_en(we1), .fifo_wr_data(wd1),
    .grant_valid(gv1), .grant_id(gid1)
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(vld), .req_data(dat), .req_ready(rr4),
    .fifo_full(full), .fifo_wr_en(we4), .fifo_wr_data(wd4),
    .grant_valid(gv4), .grant_id(gid4)
  );

  assign rr_o  = use1 ? rr1  : rr4;
  assign we_o  = use1 ? we1  : we4;
  assign wd_o  = use1 ? wd1  : wd4;
  assign gv_o  = use1 ? gv1  : gv4;
  assign gid_o = use1 ? gid1 : gid4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requesters must hold data while valid and not yet accepted.
  logic [3:0]  held = '0;
  logic [31:0] held_dat = '0;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (!rst && held[i] && vld[i])
        chk("hold_data", 32'(dat[i*8 +: 8]), 32'(held_dat[i*8 +: 8]));
    held     = vld & ~rr_o;
    held_dat = dat;
  end

  task automatic step(input logic r, input logic [3:0] v, input logic f,
                      input logic egv, input int eid, input string tag);
    logic [3:0] erdy;
    logic [7:0] edat;
    logic [9:0] item;
    @(negedge clk);
    rst = r; vld = v; full = f;
    if (egv && !f && !r) exp_q.push_back({eid[1:0], dat[eid*8 +: 8]});
    #4;
    erdy = (egv && !f && !r) ? (4'b0001 << eid) : 4'b0000;
    edat = egv ? dat[eid*8 +: 8] : 8'h00;
    chk({tag, ".grant_valid"}, 32'(gv_o), 32'(egv));
    chk({tag, ".grant_id"}, 32'(gid_o), egv ? 32'(eid) : 32'd0);
    chk({tag, ".req_ready"}, 32'(rr_o), 32'(erdy));
    chk({tag, ".wr_en"}, 32'(we_o), 32'(|erdy));
    chk({tag, ".wr_data"}, 32'(wd_o), 32'(edat));
    accepted += $countones(rr_o & vld);
    if (we_o) begin
      writes++;
      sink_q.push_back(wd_o);
      chk({tag, ".sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        item = exp_q.pop_front();
        chk({tag, ".sb_beat"}, {22'd0, gid_o, wd_o}, {22'd0, item});
      end
    end
    chk({tag, ".sb_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input logic sel1);
    use1 = sel1;
    step(1'b1, 4'b0000, 1'b0, 1'b0, 0, "rst");
    sink_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset state with every requester valid: all outputs must stay quiet.
    step(1'b1, 4'b1111, 1'b0, 1'b0, 0, "reset_state");

    // 1: per-beat round robin
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) step(1'b0, 4'b1111, 1'b0, 1'b1, k % 4, "t1_rr");
    for (int k = 0; k < 4; k++) chk("t1_readback", 32'(sink_q[k]), 32'(k * 16));

    // 2: bursts of 4 alternating req0/req2 until the 16-deep sink fills
    do_reset(1'b0);
    for (int k = 0; k < 16; k++)
      step(1'b0, 4'b0101, sink_q.size() >= 16, 1'b1, ((k / 4) % 2 == 1) ? 2 : 0, "t2_burst");
    chk("t2_sink_count", 32'(sink_q.size()), 32'd16);
    for (int k = 0; k < 2; k++)
      step(1'b0, 4'b0101, sink_q.size() >= 16, 1'b1, 0, "t2_full");

    // 3: full stalls a lock mid-burst without breaking it
    do_reset(1'b0);
    step(1'b0, 4'b0010, 1'b0, 1'b1, 1, "t3_beat1");
    step(1'b0, 4'b0010, 1'b0, 1'b1, 1, "t3_beat2");
    for (int k = 0; k < 3; k++) step(1'b0, 4'b1111, 1'b1, 1'b1, 1, "t3_stall");
    step(1'b0, 4'b1111, 1'b0, 1'b1, 1, "t3_beat3");
    step(1'b0, 4'b1111, 1'b0, 1'b1, 1, "t3_beat4");
    step(1'b0, 4'b1111, 1'b0, 1'b1, 2, "t3_next");

    // 4: owner drops valid -> one bubble, then rr continues from owner+1
    do_reset(1'b0);
    step(1'b0, 4'b0010, 1'b0, 1'b1, 1, "t4_beat1");
    step(1'b0, 4'b0010, 1'b0, 1'b1, 1, "t4_beat2");
    step(1'b0, 4'b1000, 1'b0, 1'b0, 0, "t4_bubble");
    step(1'b0, 4'b1000, 1'b0, 1'b1, 3, "t4_req3");

    // 5: wrap from the last requester back to 0
    do_reset(1'b1);
    step(1'b0, 4'b1000, 1'b0, 1'b1, 3, "t5_only3");
    step(1'b0, 4'b1001, 1'b0, 1'b1, 0, "t5_wrap0");
    step(1'b0, 4'b1001, 1'b0, 1'b1, 3, "t5_then3");

    // 6: reset mid-burst abandons the lock
    do_reset(1'b0);
    accepted = 0;
    writes = 0;
    step(1'b0, 4'b0100, 1'b0, 1'b1, 2, "t6_beat1");
    step(1'b0, 4'b0100, 1'b0, 1'b1, 2, "t6_beat2");
    step(1'b1, 4'b1111, 1'b0, 1'b0, 0, "t6_rst");
    for (int k = 0; k < 4; k++) step(1'b0, 4'b1111, 1'b0, 1'b1, 0, "t6_after");
    step(1'b0, 4'b1111, 1'b0, 1'b1, 1, "t6_next");
    chk("t6_writes_vs_accepted", 32'(writes), 32'(accepted));
    chk("t6_write_total", 32'(writes), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
